// File: rtl/binadd.sv
// Registered ripple-carry adder: {cout, s} = a + b + c.
// REG_OUT selects a one-cycle output register or a pure combinational path.
module binadd #(
  parameter int WIDTH   = 2,
  parameter bit REG_OUT = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c,
  output logic [WIDTH-1:0] s,
  output logic             cout
);

  logic [WIDTH:0]   w_carry;
  logic [WIDTH-1:0] w_sum;

  assign w_carry[0] = c;

  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    assign w_sum[i]       = a[i] ^ b[i] ^ w_carry[i];
    assign w_carry[i+1]   = (a[i] & b[i])
                          | (a[i] & w_carry[i])
                          | (b[i] & w_carry[i]);
  end

  if (REG_OUT) begin : g_reg
    logic [WIDTH-1:0] r_s;
    logic             r_cout;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_s    <= '0;
        r_cout <= 1'b0;
      end else begin
        r_s    <= w_sum;
        r_cout <= w_carry[WIDTH];
      end
    end

    assign s    = r_s;
    assign cout = r_cout;
  end else begin : g_comb
    // Clock and reset have no role on the combinational path.
    logic w_unused;
    assign w_unused = ^{clk, rst_n};
    assign s        = w_sum;
    assign cout     = w_carry[WIDTH];
  end

endmodule

// File: tb/tb_binadd.sv
// Self-checking bench for binadd: registered WIDTH=2 instance
// plus a combinational WIDTH=4 instance.
module tb_binadd;

  logic       clk;
  logic       clk_en;
  logic       rst_n;
  logic [1:0] a, b;
  logic       c;
  logic [1:0] s;
  logic       cout;
  logic [3:0] a4, b4;
  logic       c4;
  logic [3:0] s4;
  logic       cout4;

  int n_chk;
  int n_err;

  binadd #(.WIDTH(2), .REG_OUT(1'b1)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .a     (a),
    .b     (b),
    .c     (c),
    .s     (s),
    .cout  (cout)
  );

  binadd #(.WIDTH(4), .REG_OUT(1'b0)) u_comb (
    .clk   (clk),
    .rst_n (rst_n),
    .a     (a4),
    .b     (b4),
    .c     (c4),
    .s     (s4),
    .cout  (cout4)
  );

  initial clk = 1'b0;
  always #5 if (clk_en) clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog expired");
  end

  function automatic int model(input int x, input int y, input int z);
    return x + y + z;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  // Checks the registered outputs as the (WIDTH+1)-bit total.
  task automatic chk_reg(input string name, input int exp);
    chk(name, int'({cout, s}), exp);
  endtask

  task automatic drive(input int x, input int y, input int z);
    a = 2'(x);
    b = 2'(y);
    c = 1'(z);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    string      name;
    logic [1:0] va;
    logic [1:0] vb;
    logic       vc;
    logic [1:0] es;
    logic       eco;
  } vec_t;

  vec_t vecs[5];
  int   q_exp[$];

  initial begin
    vecs[0] = '{"spot_1_1_0",  2'd1, 2'd1, 1'b0, 2'd2, 1'b0};
    vecs[1] = '{"spot_3_3_0",  2'd3, 2'd3, 1'b0, 2'd2, 1'b1};
    vecs[2] = '{"ripple_3_0_1", 2'd3, 2'd0, 1'b1, 2'd0, 1'b1};
    vecs[3] = '{"ripple_2_1_1", 2'd2, 2'd1, 1'b1, 2'd0, 1'b1};
    vecs[4] = '{"zero_0_0_0",  2'd0, 2'd0, 1'b0, 2'd0, 1'b0};

    n_chk  = 0;
    n_err  = 0;
    clk_en = 1'b0;
    rst_n  = 1'b0;
    drive(3, 3, 1);
    a4 = 4'd15;
    b4 = 4'd1;
    c4 = 1'b0;

    // Reset with no clock edges at all
    #1;
    chk_reg("reset_immediate", 0);
    #20;
    chk_reg("reset_held", 0);
    clk_en = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_reg("reset_held_clocked", 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk_reg("reset_release_load", 7);

    // Table vectors
    for (int i = 0; i < 5; i++) begin
      drive(vecs[i].va, vecs[i].vb, vecs[i].vc);
      tick();
      chk({vecs[i].name, "_s"}, int'(s), int'(vecs[i].es));
      chk({vecs[i].name, "_cout"}, int'(cout), int'(vecs[i].eco));
    end

    // Exhaustive sweep, one vector per cycle
    for (int ci = 0; ci < 2; ci++)
      for (int ai = 0; ai < 4; ai++)
        for (int bi = 0; bi < 4; bi++) begin
          drive(ai, bi, ci);
          tick();
          chk($sformatf("exh_a%0d_b%0d_c%0d", ai, bi, ci),
              int'({cout, s}), model(ai, bi, ci));
        end

    // Reset asserted between edges discards the held result
    drive(3, 3, 1);
    tick();
    chk_reg("mid_pre_reset", 7);
    rst_n = 1'b0;
    #1;
    chk_reg("mid_async_clear", 0);
    drive(1, 2, 0);
    #2;
    chk_reg("mid_clear_held", 0);
    rst_n = 1'b1;
    tick();
    chk_reg("mid_release_load", 3);

    // Latency: a change just after an edge waits for the next edge
    drive(3, 2, 1);
    #3;
    chk_reg("lat_unchanged", 3);
    tick();
    chk_reg("lat_updated", 6);
    drive(0, 1, 0);
    tick();
    chk_reg("lat_seq0", 1);
    drive(2, 2, 0);
    tick();
    chk_reg("lat_seq1", 4);

    // Randomized stream against a queue-based model
    for (int i = 0; i < 60; i++) begin
      int ra, rb, rc;
      ra = int'($urandom_range(0, 3));
      rb = int'($urandom_range(0, 3));
      rc = int'($urandom_range(0, 1));
      drive(ra, rb, rc);
      q_exp.push_back(model(ra, rb, rc));
      tick();
      chk($sformatf("rand_%0d", i), int'({cout, s}), q_exp.pop_front());
    end

    // Combinational instance, reset has no effect
    #1;
    chk("comb_15_1_0", int'({cout4, s4}), 16);
    rst_n = 1'b0;
    #1;
    chk("comb_rst_low", int'({cout4, s4}), 16);
    rst_n = 1'b1;
    #1;
    chk("comb_rst_high", int'({cout4, s4}), 16);
    a4 = 4'd15;
    b4 = 4'd15;
    c4 = 1'b1;
    #1;
    chk("comb_max", int'({cout4, s4}), 31);
    for (int i = 0; i < 20; i++) begin
      int ra, rb, rc;
      ra = int'($urandom_range(0, 15));
      rb = int'($urandom_range(0, 15));
      rc = int'($urandom_range(0, 1));
      a4 = 4'(ra);
      b4 = 4'(rb);
      c4 = 1'(rc);
      #1;
      chk($sformatf("comb_rand_%0d", i), int'({cout4, s4}),
          model(ra, rb, rc));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
